// File: rtl/divfreq_pkg.sv
// Shared constants and helpers for the divisor_frequencia_multi clock-enable generator.
// Optional square-wave outputs are enabled with the DIVFREQ_SQUARE_EN macro.
package divfreq_pkg;

    localparam int DIVFREQ_MAX_CH = 16;

    // Width of a channel index; a single channel still needs a 1-bit select.
    function automatic int ch_w(input int n_ch);
        return (n_ch <= 2) ? 1 : $clog2(n_ch);
    endfunction

endpackage

// File: rtl/divfreq_canal.sv
// One divider channel: programmable divisor, counter, registered tick and optional
// square-wave flop (DIVFREQ_SQUARE_EN).
module divfreq_canal
    import divfreq_pkg::*;
#(
    parameter int          CNT_W   = 16,
    parameter int unsigned DIV_RST = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             src,
    input  logic             load,
    input  logic [CNT_W-1:0] load_div,
    input  logic             load_casc,
    output logic             casc,
    output logic             tick
`ifdef DIVFREQ_SQUARE_EN
    ,
    output logic             sq
`endif
);

    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] cnt;
    logic             step;
    logic             term;

    // A divisor of zero parks the channel without touching its phase.
    assign step = en && src && (div != '0);
    assign term = step && (cnt == div - CNT_W'(1));

    // NOTE: sequential state uses non-blocking assignments so every channel and the
    // cascade mux observe pre-edge values of tick within the same clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            div  <= CNT_W'(DIV_RST);
            casc <= 1'b0;
            cnt  <= '0;
            tick <= 1'b0;
        end else if (load) begin
            // A write beats a coincident terminal count and restarts from zero.
            div  <= load_div;
            casc <= load_casc;
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= term;
            if (term) begin
                cnt <= '0;
            end else if (step) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

`ifdef DIVFREQ_SQUARE_EN
    always_ff @(posedge clk) begin
        if (rst || load) begin
            sq <= 1'b0;
        end else if (term) begin
            sq <= ~sq;
        end
    end
`endif

endmodule

// File: rtl/divisor_frequencia_multi.sv
// Multi-channel clock-enable generator: per-channel divisors, optional cascading on the
// previous channel's tick, and 50 % square waves when DIVFREQ_SQUARE_EN is defined.
module divisor_frequencia_multi
    import divfreq_pkg::*;
#(
    parameter int          N_CH    = 3,
    parameter int          CNT_W   = 16,
    parameter int unsigned DIV_RST = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    cfg_we,
    input  logic [ch_w(N_CH)-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]        cfg_div,
    input  logic                    cfg_casc,
    output logic [N_CH-1:0]         tick,
`ifdef DIVFREQ_SQUARE_EN
    output logic [N_CH-1:0]         sq,
`endif
    output logic                    cfg_ack,
    output logic                    cfg_err
);

    localparam int CH_W = ch_w(N_CH);

    logic            wr_ok;
    logic [N_CH-1:0] casc;
    logic [N_CH-1:0] prev_tick;
    logic [N_CH-1:0] src;

    assign wr_ok = cfg_we && (int'(cfg_ch) < N_CH);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        // Channel 0 has no predecessor; its cascade bit is always loaded as 0.
        if (g == 0) begin : g_first
            assign prev_tick[g] = 1'b0;
        end else begin : g_next
            assign prev_tick[g] = tick[g-1];
        end

        assign src[g] = ~casc[g] | prev_tick[g];

        divfreq_canal #(
            .CNT_W   (CNT_W),
            .DIV_RST (DIV_RST)
        ) u_canal (
            .clk       (clk),
            .rst       (rst),
            .en        (en),
            .src       (src[g]),
            .load      (wr_ok && (cfg_ch == CH_W'(g))),
            .load_div  (cfg_div),
            .load_casc (cfg_casc && (g != 0)),
            .casc      (casc[g]),
            .tick      (tick[g])
`ifdef DIVFREQ_SQUARE_EN
            ,
            .sq        (sq[g])
`endif
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_ack <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            cfg_ack <= wr_ok;
            cfg_err <= cfg_we && !wr_ok;
        end
    end

endmodule

// File: tb/tb_divisor_frequencia_multi.sv
// Self-checking bench for divisor_frequencia_multi: directed scenarios plus random traffic,
// compared every cycle against an event-count reference model.
module tb_divisor_frequencia_multi;

    localparam int N_CH    = 3;
    localparam int CNT_W   = 8;
    localparam int DIV_RST = 0;
    localparam int CH_W    = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic              cfg_casc;
    logic [N_CH-1:0]   tick;
`ifdef DIVFREQ_SQUARE_EN
    logic [N_CH-1:0]   sq;
`endif
    logic              cfg_ack;
    logic              cfg_err;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: each channel remembers how many counting steps it has taken since
    // its last write/reset; a tick is every D-th step and sq is the parity of D-blocks.
    int m_div  [N_CH];
    bit m_casc [N_CH];
    int m_ev   [N_CH];
    bit m_tick [N_CH];
    bit m_ack;
    bit m_err;

    divisor_frequencia_multi #(
        .N_CH    (N_CH),
        .CNT_W   (CNT_W),
        .DIV_RST (DIV_RST)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .cfg_casc (cfg_casc),
        .tick     (tick),
`ifdef DIVFREQ_SQUARE_EN
        .sq       (sq),
`endif
        .cfg_ack  (cfg_ack),
        .cfg_err  (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit prev [N_CH];
        for (int c = 0; c < N_CH; c++) prev[c] = m_tick[c];
        if (rst) begin
            for (int c = 0; c < N_CH; c++) begin
                m_div[c]  = DIV_RST;
                m_casc[c] = 1'b0;
                m_ev[c]   = 0;
                m_tick[c] = 1'b0;
            end
            m_ack = 1'b0;
            m_err = 1'b0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                bit s;
                if (cfg_we && int'(cfg_ch) == c) begin
                    m_div[c]  = int'(cfg_div);
                    m_casc[c] = (c > 0) && cfg_casc;
                    m_ev[c]   = 0;
                    m_tick[c] = 1'b0;
                end else begin
                    s = 1'b1;
                    if (c > 0 && m_casc[c]) s = prev[c-1];
                    if (en && s && m_div[c] != 0) begin
                        m_ev[c]++;
                        m_tick[c] = (m_ev[c] % m_div[c]) == 0;
                    end else begin
                        m_tick[c] = 1'b0;
                    end
                end
            end
            m_ack = cfg_we && (int'(cfg_ch) <  N_CH);
            m_err = cfg_we && (int'(cfg_ch) >= N_CH);
        end
    endtask

    task automatic compare_all();
        logic [N_CH-1:0] et;
        logic [N_CH-1:0] es;
        for (int c = 0; c < N_CH; c++) begin
            et[c] = m_tick[c];
            es[c] = (m_div[c] != 0) ? (((m_ev[c] / m_div[c]) % 2) == 1) : 1'b0;
        end
        check("tick", 32'(tick), 32'(et));
`ifdef DIVFREQ_SQUARE_EN
        check("sq", 32'(sq), 32'(es));
`endif
        check("cfg_ack", 32'(cfg_ack), 32'(m_ack));
        check("cfg_err", 32'(cfg_err), 32'(m_err));
    endtask

    // One clock: DUT samples current inputs, model follows, outputs compared 1 ns later.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        cfg_we = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic wr(input int ch, input int d, input bit c);
        cfg_we   = 1'b1;
        cfg_ch   = CH_W'(ch);
        cfg_div  = CNT_W'(d);
        cfg_casc = c;
        cycle();
    endtask

    initial begin
        int last_t1;
        int n_t1;
        logic prev_t0;

        for (int c = 0; c < N_CH; c++) begin
            m_div[c] = DIV_RST; m_casc[c] = 1'b0; m_ev[c] = 0; m_tick[c] = 1'b0;
        end
        m_ack = 1'b0; m_err = 1'b0;
        rst = 1'b1; en = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_casc = 1'b0;
        #1;

        // Reset state.
        run(2);
        check("rst_tick", 32'(tick), 32'd0);
        rst = 1'b0;
        en  = 1'b1;
        run(3);

        // ch0 D=4: first tick on the 4th counting edge after the write.
        wr(0, 4, 1'b0);
        check("ack_after_wr", 32'(cfg_ack), 32'd1);
        run(3);
        cycle();
        check("first_tick_d4", 32'(tick[0]), 32'd1);
        run(20);

        // ch1 cascaded D=3 on ch0: period 12, always one cycle after a ch0 tick.
        wr(1, 3, 1'b1);
        last_t1 = -1;
        n_t1    = 0;
        prev_t0 = tick[0];
        for (int cyc = 0; cyc < 60; cyc++) begin
            cycle();
            if (tick[1]) begin
                n_t1++;
                check("casc_follow", 32'(prev_t0), 32'd1);
                if (last_t1 >= 0) check("casc_period", 32'(cyc - last_t1), 32'd12);
                last_t1 = cyc;
            end
            prev_t0 = tick[0];
        end
        check("casc_seen", 32'(n_t1 >= 4), 32'd1);

        // D=1 ticks every cycle, then D=0 halts for 100 cycles.
        wr(2, 1, 1'b0);
        run(3);
        check("d1_tick", 32'(tick[2]), 32'd1);
        run(8);
        wr(2, 0, 1'b0);
        run(100);
        check("d0_halt", 32'(tick[2]), 32'd0);

        // Pause with ch0 counter at 2 for 5 cycles; resume keeps phase.
        for (int i = 0; i < 8 && (m_ev[0] % 4) != 2; i++) cycle();
        en = 1'b0;
        run(5);
        en = 1'b1;
        cycle();
        check("resume_wait", 32'(tick[0]), 32'd0);
        cycle();
        check("resume_tick", 32'(tick[0]), 32'd1);
        run(6);

        // Write on the terminal-count edge suppresses the tick and restarts.
        for (int i = 0; i < 8 && (m_ev[0] % 4) != 3; i++) cycle();
        wr(0, 4, 1'b0);
        check("wr_beats_tc", 32'(tick[0]), 32'd0);
        run(3);
        cycle();
        check("tick_after_wr", 32'(tick[0]), 32'd1);

        // Out-of-range channel: error pulse, nothing changes.
        wr(3, 7, 1'b1);
        check("err_pulse", 32'(cfg_err), 32'd1);
        check("err_no_ack", 32'(cfg_ack), 32'd0);
        run(16);

        // Reset mid-count with D=5: everything back to zero and halted.
        wr(0, 5, 1'b0);
        run(2);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("midrst_tick", 32'(tick), 32'd0);
        check("midrst_ack", 32'(cfg_ack), 32'd0);
        n_t1 = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            n_t1 += int'(tick != '0);
        end
        check("halted_after_rst", 32'(n_t1), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            en  = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 5) == 0) begin
                cfg_we   = 1'b1;
                cfg_ch   = CH_W'($urandom_range(0, 3));
                cfg_div  = CNT_W'($urandom_range(0, 6));
                cfg_casc = 1'($urandom_range(0, 1));
            end
            cycle();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
